ctc_int_ctrl: RTL and testbench

//  Interrupt controller for the CTC, sitting directly downstream of the counter

---
 rtl/ctc_pkg.sv | 20 ++
 rtl/ctc_int_ctrl_if.sv | 22 ++
 rtl/ctc_reti_detect.sv | 67 ++++++
 rtl/ctc_int_ctrl.sv | 111 +++++++++++
 tb/tb_ctc_int_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctc_pkg.sv
// CTC interrupt controller shared definitions.
// Opcodes, RETI detector states and vector assembly.
package ctc_pkg;

  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_RETI2 = 8'h4D;

  typedef enum logic {
    R_IDLE,
    R_ED
  } reti_st_t;

  function automatic logic [7:0] ctc_vec(
    input logic [4:0] base,
    input logic [1:0] ch
  );
    return {base, ch, 1'b0};
  endfunction

endpackage

// File: rtl/ctc_int_ctrl_if.sv
// Z80 bus slice seen by the CTC interrupt controller.
// master = CPU side, slave = controller side.
interface ctc_int_ctrl_if #(
  parameter int DWID = 8
);
  logic            m1_n;
  logic            iorq_n;
  logic            rd_n;
  logic [DWID-1:0] din;
  logic [DWID-1:0] dout;
  logic            dout_oe;

  modport master (
    output m1_n, iorq_n, rd_n, din,
    input  dout, dout_oe
  );

  modport slave (
    input  m1_n, iorq_n, rd_n, din,
    output dout, dout_oe
  );
endinterface

// File: rtl/ctc_reti_detect.sv
// Opcode capture and RETI (ED 4D) detector.
// Emits a one-clk reti pulse at the end of the 4D fetch.
module ctc_reti_detect
  import ctc_pkg::*;
#(
  parameter int DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m1_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic [DWID-1:0] din,
  input  logic            ack_start,
  output logic            reti
);

  logic       fetch;
  logic       fetch_q;
  logic       fetch_end;
  logic [7:0] op;
  reti_st_t   st;
  reti_st_t   st_nx;

  assign fetch     = ~m1_n & ~rd_n & iorq_n;
  assign fetch_end = fetch_q & ~fetch;

  // latch the opcode byte and track fetch boundaries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_q <= 1'b0;
      op      <= '0;
      st      <= R_IDLE;
    end else begin
      fetch_q <= fetch;
      if (fetch) op <= din[7:0];
      st <= st_nx;
    end
  end

  // decode the latched byte once per completed fetch
  always_comb begin
    st_nx = st;
    reti  = 1'b0;
    if (ack_start) begin
      st_nx = R_IDLE;
    end else if (fetch_end) begin
      unique case (st)
        R_IDLE: begin
          if (op == OP_ED) st_nx = R_ED;
        end
        R_ED: begin
          if (op == OP_RETI2) begin
            reti  = 1'b1;
            st_nx = R_IDLE;
          end else if (op == OP_ED) begin
            st_nx = R_ED;
          end else begin
            st_nx = R_IDLE;
          end
        end
        default: st_nx = R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ctc_int_ctrl.sv
// CTC interrupt controller: pending/in-service tracking,
// fixed-priority daisy-chain arbitration and mode-2 vector.
module ctc_int_ctrl
  import ctc_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  ctc_int_ctrl_if.slave   bus,
  input  logic [N_CH-1:0] int_req,
  input  logic [N_CH-1:0] int_en,
  input  logic [4:0]      vec_base,
  input  logic            iei,
  output logic            ieo,
  output logic            int_n
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] serv;
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] svc_lo;
  logic [N_CH-1:0] ack_oh;
  logic [N_CH-1:0] rel;
  logic [N_CH-1:0] pend_nx;
  logic [N_CH-1:0] serv_nx;
  logic [1:0]      k;
  logic            any_elig;
  logic            blocked;
  logic            acc;
  logic            acc_q;
  logic            ack_start;
  logic            ack_go;
  logic            reti;
  logic [DWID-1:0] dout_r;
  logic            oe_r;

  assign acc       = ~bus.m1_n & ~bus.iorq_n;
  assign ack_start = acc & ~acc_q;
  assign ack_go    = ack_start & iei & any_elig;

  assign bus.dout    = dout_r;
  assign bus.dout_oe = oe_r;

  assign ieo = iei & ~|serv & ~(|pend & ~bus.m1_n);

  ctc_reti_detect #(.DWID(DWID)) u_reti (
    .clk       (clk),
    .reset_n   (reset_n),
    .m1_n      (bus.m1_n),
    .iorq_n    (bus.iorq_n),
    .rd_n      (bus.rd_n),
    .din       (bus.din),
    .ack_start (ack_start),
    .reti      (reti)
  );

  // priority: eligibility, winner index, lowest in-service bit
  always_comb begin
    elig     = '0;
    svc_lo   = '0;
    k        = '0;
    any_elig = 1'b0;
    blocked  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      blocked = blocked | serv[i];
      elig[i] = pend[i] & ~blocked;
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        k        = 2'(i);
        any_elig = 1'b1;
      end
      if (serv[i]) svc_lo = N_CH'(1) << i;
    end
  end

  // next pend/serv; a request coinciding with its ack stays queued
  always_comb begin
    ack_oh  = ack_go ? (N_CH'(1) << k) : '0;
    rel     = (reti & iei) ? svc_lo : '0;
    pend_nx = ((pend & ~ack_oh) | (int_req & int_en)) & int_en;
    serv_nx = (serv & ~rel) | ack_oh;
  end

  // state, registered int_n and vector drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend   <= '0;
      serv   <= '0;
      acc_q  <= 1'b0;
      int_n  <= 1'b1;
      dout_r <= '0;
      oe_r   <= 1'b0;
    end else begin
      pend  <= pend_nx;
      serv  <= serv_nx;
      acc_q <= acc;
      int_n <= ~(iei & any_elig);
      if (ack_go) begin
        dout_r <= DWID'(ctc_vec(vec_base, k));
        oe_r   <= 1'b1;
      end else if (!acc) begin
        dout_r <= '0;
        oe_r   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctc_int_ctrl.sv
// Directed bench for ctc_int_ctrl.
// Vectors go through a scoreboard queue; state via immediate asserts.
module tb_ctc_int_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] int_req;
  logic [3:0] int_en;
  logic [4:0] vec_base;
  logic       iei;
  logic       ieo;
  logic       int_n;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rc = 0;
  int         r0;
  logic [7:0] sb[$];
  logic       oe_q = 1'b0;

  ctc_int_ctrl_if #(.DWID(8)) bus ();

  ctc_int_ctrl #(.N_CH(4), .DWID(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .int_req  (int_req),
    .int_en   (int_en),
    .vec_base (vec_base),
    .iei      (iei),
    .ieo      (ieo),
    .int_n    (int_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // vector scoreboard: pop on each rising dout_oe
  always @(negedge clk) begin
    if (bus.dout_oe === 1'b1 && oe_q !== 1'b1) begin
      chk("sb_avail", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) chk("vector", bus.dout, sb.pop_front());
    end
    oe_q <= bus.dout_oe;
  end

  // count reti pulses
  always @(posedge clk) begin
    if (dut.reti === 1'b1) rc <= rc + 1;
  end

  task automatic fetch(input logic [7:0] op);
    bus.m1_n = 1'b0; bus.rd_n = 1'b0; bus.iorq_n = 1'b1; bus.din = op;
    tick;
    bus.m1_n = 1'b1; bus.rd_n = 1'b1; bus.din = 8'h00;
    tick;
  endtask

  task automatic reti2;
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  task automatic ack(input bit drive, input logic [7:0] v);
    if (drive) sb.push_back(v);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0; bus.rd_n = 1'b1;
    tick;
    chk("ack_oe", bus.dout_oe, drive);
    tick;
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    tick;
    chk("rel_oe", bus.dout_oe, 0);
    chk("rel_dout", bus.dout, 0);
  endtask

  task automatic pulse(input logic [3:0] r);
    int_req = r;
    tick;
    int_req = 4'h0;
    tick;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.din = 8'h00;
    int_req = 4'h0; int_en = 4'hF; vec_base = 5'b10100; iei = 1'b1;
    tick; tick;
    chk("rst_int_n", int_n, 1);
    chk("rst_oe", bus.dout_oe, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_ieo", ieo, 1);
    reset_n = 1'b1;
    tick;

    // single request on channel 2
    pulse(4'b0100);
    chk("t1_int_n", int_n, 0);
    chk("t1_ieo", ieo, 1);
    chk("t1_pend", dut.pend, 4'b0100);
    ack(1, 8'hA4);
    chk("t1_serv", dut.serv, 4'b0100);
    chk("t1_pend_clr", dut.pend, 0);
    chk("t1_int_n_hi", int_n, 1);
    chk("t1_ieo_lo", ieo, 0);
    reti2;
    chk("t1_reti", dut.serv, 0);

    // simultaneous 1 and 3
    pulse(4'b1010);
    chk("t2_int_n", int_n, 0);
    ack(1, 8'hA2);
    chk("t2_serv", dut.serv, 4'b0010);
    chk("t2_pend", dut.pend, 4'b1000);
    chk("t2_int_n_hi", int_n, 1);
    reti2;
    chk("t2_reti", dut.serv, 0);
    tick;
    chk("t2_int_n_ch3", int_n, 0);
    ack(1, 8'hA6);
    reti2;
    chk("t2_clean", dut.serv, 0);

    // nesting: channel 0 over channel 2
    pulse(4'b0100);
    ack(1, 8'hA4);
    pulse(4'b0001);
    chk("t3_int_n", int_n, 0);
    ack(1, 8'hA0);
    chk("t3_serv", dut.serv, 4'b0101);
    reti2;
    chk("t3_reti1", dut.serv, 4'b0100);
    reti2;
    chk("t3_reti2", dut.serv, 0);

    // request coincident with own acknowledge stays queued
    pulse(4'b0100);
    sb.push_back(8'hA4);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0; int_req = 4'b0100;
    tick;
    int_req = 4'h0;
    chk("q_pend", dut.pend, 4'b0100);
    chk("q_serv", dut.serv, 4'b0100);
    tick;
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    tick;
    reti2;
    tick;
    chk("q_int_n", int_n, 0);
    ack(1, 8'hA4);
    reti2;
    chk("q_pend_clr", dut.pend, 0);
    chk("q_serv_clr", dut.serv, 0);

    // disabling a channel drops its pending request
    int_req = 4'b0001;
    tick;
    int_req = 4'h0;
    chk("en_pend", dut.pend, 4'b0001);
    int_en = 4'hE;
    tick;
    chk("en_clr", dut.pend, 0);
    int_en = 4'hF;
    tick; tick;
    chk("en_int_n", int_n, 1);

    // iei low: upstream device owns the chain
    pulse(4'b0100);
    ack(1, 8'hA4);
    iei = 1'b0;
    pulse(4'b0001);
    chk("t4_int_n", int_n, 1);
    chk("t4_ieo", ieo, 0);
    ack(0, 8'h00);
    chk("t4_pend", dut.pend, 4'b0001);
    chk("t4_serv", dut.serv, 4'b0100);
    reti2;
    chk("t4_reti_ign", dut.serv, 4'b0100);
    iei = 1'b1;
    do_reset;

    // RETI sequence recognition
    r0 = rc;
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    chk("t5_ed_ed_4d", rc - r0, 1);
    r0 = rc;
    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    chk("t5_ed_00_4d", rc - r0, 0);
    r0 = rc;
    fetch(8'hED);
    ack(0, 8'h00);
    fetch(8'h4D);
    chk("t5_ed_ack_4d", rc - r0, 0);

    // reset in the middle of an acknowledge
    pulse(4'b1010);
    sb.push_back(8'hA2);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    tick;
    chk("t6_oe", bus.dout_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_oe_rst", bus.dout_oe, 0);
    chk("t6_dout_rst", bus.dout, 0);
    chk("t6_pend", dut.pend, 0);
    chk("t6_serv", dut.serv, 0);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    tick;
    reset_n = 1'b1;
    tick;
    chk("t6_int_n", int_n, 1);
    chk("t6_ieo", ieo, 1);
    iei = 1'b0;
    #1;
    chk("t6_ieo_iei", ieo, 0);
    iei = 1'b1;
    tick;

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
